// File: rtl/tuple_array_serializer_if.sv
// Bundle interface for tuple_array_serializer.
// Carries the captured-frame input side (I0 strobe, I1 tag, I2 mode tuple,
// I3 entry array, I_ready) and the serialized beat stream (O_valid/O_ready,
// O_tag, O_idx, O_B, O_C, O_last, O_drop).
//   master : frame source and beat sink (drives I*, O_ready)
//   slave  : serializer (drives I_ready and O_* beat fields)
interface tuple_array_serializer_if #(
    parameter int N  = 5,
    parameter int W  = 5,
    parameter int IW = $clog2(N)
);
    logic          I0;
    logic [W-1:0]  I1;
    logic          I2_B;
    logic          I2_C;
    logic [N-1:0]  I3_B;
    logic [N-1:0]  I3_C;
    logic          I_ready;
    logic          O_valid;
    logic          O_ready;
    logic [W-1:0]  O_tag;
    logic [IW-1:0] O_idx;
    logic          O_B;
    logic          O_C;
    logic          O_last;
    logic          O_drop;

    modport master (
        output I0, I1, I2_B, I2_C, I3_B, I3_C, O_ready,
        input  I_ready, O_valid, O_tag, O_idx, O_B, O_C, O_last, O_drop
    );

    modport slave (
        input  I0, I1, I2_B, I2_C, I3_B, I3_C, O_ready,
        output I_ready, O_valid, O_tag, O_idx, O_B, O_C, O_last, O_drop
    );
endinterface

// File: rtl/tuple_array_serializer.sv
// tuple_array_serializer
// Captures a tuple-array frame on I0 & I_ready and emits its (B, C) entries
// one per ready/valid beat, tagged with the frame tag, entry index and a last
// flag. I2_B enables compaction (entries with B==0 are skipped), I2_C selects
// reverse scan order. A frame whose mask is empty produces a one-cycle O_drop.
// Ports:
//   CLK        rising-edge clock
//   ASYNCRESET asynchronous active-high reset, aborts any frame in flight
//   bus        tuple_array_serializer_if.slave (frame input + beat stream)
// All outputs come from registers or are decoded from registers only.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a frame; I_ready=1
// SEND  | presenting entry idx_q; advance on O_ready, leave after O_last
module tuple_array_serializer #(
    parameter int N  = 5,
    parameter int W  = 5,
    parameter int IW = $clog2(N)
) (
    input  logic CLK,
    input  logic ASYNCRESET,
    tuple_array_serializer_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state, state_d;
    logic [W-1:0]  tag_q, tag_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  c_q, c_d;
    logic [N-1:0]  mask_q, mask_d;
    logic          rev_q, rev_d;
    logic          drop_q, drop_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [N-1:0]  mask_in;
    logic          has_next;
    logic [IW-1:0] next_idx;

    // First set bit of m in scan order (0 upward, or N-1 downward when rev).
    function automatic logic [IW-1:0] scan_first(input logic [N-1:0] m,
                                                 input logic rev);
        logic [IW-1:0] pos;
        logic [IW-1:0] p;
        logic          found;
        pos   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            p = rev ? IW'(N - 1 - i) : IW'(i);
            if (!found && m[p]) begin
                pos   = p;
                found = 1'b1;
            end
        end
        return pos;
    endfunction

    // Next set bit strictly beyond cur in scan order; MSB of result = found.
    function automatic logic [IW:0] scan_next(input logic [N-1:0]  m,
                                              input logic [IW-1:0] cur,
                                              input logic          rev);
        logic [IW-1:0] pos;
        logic [IW-1:0] p;
        logic          found;
        logic          beyond;
        pos   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            p      = rev ? IW'(N - 1 - i) : IW'(i);
            beyond = rev ? (p < cur) : (p > cur);
            if (!found && beyond && m[p]) begin
                pos   = p;
                found = 1'b1;
            end
        end
        return {found, pos};
    endfunction

    assign mask_in              = bus.I2_B ? bus.I3_B : {N{1'b1}};
    assign {has_next, next_idx} = scan_next(mask_q, idx_q, rev_q);

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state  <= IDLE;
            tag_q  <= '0;
            b_q    <= '0;
            c_q    <= '0;
            mask_q <= '0;
            rev_q  <= 1'b0;
            drop_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            state  <= state_d;
            tag_q  <= tag_d;
            b_q    <= b_d;
            c_q    <= c_d;
            mask_q <= mask_d;
            rev_q  <= rev_d;
            drop_q <= drop_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        tag_d   = tag_q;
        b_d     = b_q;
        c_d     = c_q;
        mask_d  = mask_q;
        rev_d   = rev_q;
        drop_d  = 1'b0;
        idx_d   = idx_q;

        case (state)
            IDLE: begin
                if (bus.I0) begin
                    tag_d  = bus.I1;
                    b_d    = bus.I3_B;
                    c_d    = bus.I3_C;
                    mask_d = mask_in;
                    rev_d  = bus.I2_C;
                    if (mask_in == '0) begin
                        // Nothing to send: stay ready, flag the dropped frame.
                        drop_d = 1'b1;
                    end else begin
                        state_d = SEND;
                        idx_d   = scan_first(mask_in, bus.I2_C);
                    end
                end
            end
            SEND: begin
                if (bus.O_ready) begin
                    if (!has_next) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = next_idx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.I_ready = (state == IDLE);
    assign bus.O_valid = (state == SEND);
    assign bus.O_tag   = tag_q;
    assign bus.O_idx   = idx_q;
    assign bus.O_B     = b_q[idx_q];
    assign bus.O_C     = c_q[idx_q];
    assign bus.O_last  = (state == SEND) && !has_next;
    assign bus.O_drop  = drop_q;

endmodule

// File: tb/tb_tuple_array_serializer.sv
// Self-checking bench for tuple_array_serializer: directed frames, a queue
// model of the expected beat sequence, and one negedge compare process.
module tb_tuple_array_serializer;

    logic CLK;
    logic ASYNCRESET;

    tuple_array_serializer_if #(.N(5), .W(5), .IW(3)) bus ();

    tuple_array_serializer #(.N(5), .W(5), .IW(3)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .bus        (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] idx;
        logic       b;
        logic       c;
        logic       last;
        logic [4:0] tag;
    } beat_t;

    beat_t exp_q[$];
    logic  exp_drop;
    int    total;
    int    bad;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Model: list the entries that survive compaction in scan order.
    function automatic int push_frame(input logic [4:0] tag, input logic cmp,
                                      input logic rev, input logic [4:0] b,
                                      input logic [4:0] c);
        int    order[$];
        int    i;
        beat_t e;
        for (int k = 0; k < 5; k++) begin
            i = rev ? 4 - k : k;
            if (!cmp || b[i]) order.push_back(i);
        end
        for (int j = 0; j < order.size(); j++) begin
            e.idx  = 3'(order[j]);
            e.b    = b[order[j]];
            e.c    = c[order[j]];
            e.last = (j == order.size() - 1);
            e.tag  = tag;
            exp_q.push_back(e);
        end
        return order.size();
    endfunction

    task automatic set_in(input logic i0, input logic [4:0] tag, input logic cmp,
                          input logic rev, input logic [4:0] b, input logic [4:0] c);
        bus.I0   = i0;
        bus.I1   = tag;
        bus.I2_B = cmp;
        bus.I2_C = rev;
        bus.I3_B = b;
        bus.I3_C = c;
    endtask

    // One clock: acceptance is judged just before the edge, the model is
    // updated at the edge, and control returns 1 time unit after it.
    task automatic tick();
        logic acc;
        int   n;
        @(negedge CLK);
        acc = bus.I0 && bus.I_ready && !ASYNCRESET;
        @(posedge CLK);
        exp_drop = 1'b0;
        if (acc) begin
            n = push_frame(bus.I1, bus.I2_B, bus.I2_C, bus.I3_B, bus.I3_C);
            if (n == 0) exp_drop = 1'b1;
        end
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_I_ready"}, 32'(bus.I_ready), 32'd1);
        check({tag, "_O_valid"}, 32'(bus.O_valid), 32'd0);
        check({tag, "_O_last"},  32'(bus.O_last),  32'd0);
        check({tag, "_O_drop"},  32'(bus.O_drop),  32'd0);
        check({tag, "_O_tag"},   32'(bus.O_tag),   32'd0);
        check({tag, "_O_idx"},   32'(bus.O_idx),   32'd0);
        check({tag, "_O_B"},     32'(bus.O_B),     32'd0);
        check({tag, "_O_C"},     32'(bus.O_C),     32'd0);
    endtask

    always @(negedge CLK) begin
        check("valid", 32'(bus.O_valid), 32'(exp_q.size() != 0));
        check("I_ready", 32'(bus.I_ready), 32'(exp_q.size() == 0));
        check("drop", 32'(bus.O_drop), 32'(exp_drop));
        if (bus.O_valid && exp_q.size() != 0) begin
            check("beat_idx",  32'(bus.O_idx),  32'(exp_q[0].idx));
            check("beat_B",    32'(bus.O_B),    32'(exp_q[0].b));
            check("beat_C",    32'(bus.O_C),    32'(exp_q[0].c));
            check("beat_tag",  32'(bus.O_tag),  32'(exp_q[0].tag));
            check("beat_last", 32'(bus.O_last), 32'(exp_q[0].last));
            if (bus.O_ready) void'(exp_q.pop_front());
        end else begin
            check("last_idle", 32'(bus.O_last), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [4:0] b2b_b [12];
    logic [4:0] b2b_c [12];

    initial begin
        total       = 0;
        bad         = 0;
        exp_drop    = 1'b0;
        ASYNCRESET  = 1'b1;
        bus.O_ready = 1'b1;
        set_in(1'b0, 5'h00, 1'b0, 1'b0, 5'b00000, 5'b00000);
        repeat (2) @(posedge CLK);
        #1;
        check_reset_vals("rst");
        ASYNCRESET = 1'b0;
        tick();

        // Forward, no compaction, with a 3-cycle stall at idx 2 and an
        // ignored strobe while sending.
        set_in(1'b1, 5'h13, 1'b0, 1'b0, 5'b10110, 5'b01101);
        tick();
        bus.I0 = 1'b0;
        check("fwd_model_len",   32'(exp_q.size()), 32'd5);
        check("fwd_model_b0c0",  32'({exp_q[0].b, exp_q[0].c}), 32'b01);
        check("fwd_model_last4", 32'({exp_q[4].idx, exp_q[4].last}), 32'b1001);
        tick();
        tick();
        bus.O_ready = 1'b0;
        set_in(1'b1, 5'h1f, 1'b1, 1'b1, 5'b00001, 5'b11111);
        for (int k = 0; k < 3; k++) begin
            check("stall_idx", 32'(bus.O_idx), 32'd2);
            check("stall_BC",  32'({bus.O_B, bus.O_C}), 32'b11);
            check("stall_tag", 32'(bus.O_tag), 32'h13);
            tick();
        end
        bus.O_ready = 1'b1;
        bus.I0      = 1'b0;
        drain();

        // Compaction + reverse: idx 4, 2, 1.
        set_in(1'b1, 5'h0a, 1'b1, 1'b1, 5'b10110, 5'b01101);
        tick();
        bus.I0 = 1'b0;
        check("rev_model_len", 32'(exp_q.size()), 32'd3);
        check("rev_model_idx", 32'({exp_q[0].idx, exp_q[1].idx, exp_q[2].idx}), 32'b100_010_001);
        drain();
        check("rev_ready_after", 32'(bus.I_ready), 32'd1);

        // Empty mask.
        set_in(1'b1, 5'h07, 1'b1, 1'b0, 5'b00000, 5'b11111);
        tick();
        bus.I0 = 1'b0;
        check("empty_drop",    32'(bus.O_drop),  32'd1);
        check("empty_valid",   32'(bus.O_valid), 32'd0);
        check("empty_ready",   32'(bus.I_ready), 32'd1);
        tick();
        check("empty_drop_end", 32'(bus.O_drop), 32'd0);

        // Mid-frame asynchronous reset during idx 1.
        set_in(1'b1, 5'h15, 1'b0, 1'b0, 5'b10110, 5'b01101);
        tick();
        bus.I0 = 1'b0;
        tick();
        check("pre_rst_idx", 32'(bus.O_idx), 32'd1);
        #2;
        ASYNCRESET = 1'b1;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        exp_drop = 1'b0;
        tick();
        ASYNCRESET = 1'b0;
        set_in(1'b1, 5'h0c, 1'b1, 1'b0, 5'b11010, 5'b00101);
        tick();
        bus.I0 = 1'b0;
        check("post_rst_first", 32'(exp_q[0].idx), 32'd1);
        drain();

        // Back-to-back frames with I0 held high.
        b2b_b = '{5'b00001, 5'b10000, 5'b11111, 5'b00000, 5'b01010, 5'b10001,
                  5'b00100, 5'b11011, 5'b00011, 5'b01100, 5'b10101, 5'b00010};
        b2b_c = '{5'b11111, 5'b01010, 5'b00000, 5'b10101, 5'b11001, 5'b00110,
                  5'b10010, 5'b01111, 5'b11100, 5'b00001, 5'b01011, 5'b10100};
        for (int k = 0; k < 12; k++) begin
            set_in(1'b1, 5'(k + 1), 1'(k % 2 == 0), 1'(k % 3 == 1), b2b_b[k], b2b_c[k]);
            tick();
        end
        bus.I0 = 1'b0;
        drain();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tuple_array_serializer.md
# tuple_array_serializer

Downstream consumer for the flattened tuple-array bundle emitted by `Circuit`: a 1-bit strobe `I0`, a 5-bit tag `I1`, a mode tuple (`I2_B`, `I2_C`) and a 5-entry array of (B, C) bit tuples (`I3`). On each strobe the block captures the whole bundle and serializes the array onto a ready/valid stream, one (B, C) entry per beat. Each beat carries the captured tag, the entry index and a last flag. The mode tuple selects compaction, which skips entries whose B is 0, and selects reverse scan order.

## Interface
Parameters:
- `N`, 5: number of array entries; must be ≥ 2.
- `W`, 5: tag width.
- `IW`, $clog2(N) (3 for N=5): index width.

Ports:
- `CLK`  in  1  rising-edge clock
- `ASYNCRESET`  in  1  reset, asynchronous, active-high
- `I0`  in  1  load strobe; a frame is accepted when `I0 & I_ready`
- `I1`  in  W  frame tag
- `I2_B`  in  1  compaction mode: 1 = skip entries with B==0
- `I2_C`  in  1  reverse mode: 1 = emit index N-1 down to 0
- `I3_B`  in  N  B field of each entry; bit i = entry i
- `I3_C`  in  N  C field of each entry; bit i = entry i
- `I_ready`  out  1  high when a frame can be accepted
- `O_valid`  out  1  output beat valid
- `O_ready`  in  1  downstream accepts the beat
- `O_tag`  out  W  captured tag
- `O_idx`  out  IW  index of the current entry
- `O_B`, `O_C`  out  1 each  current entry fields
- `O_last`  out  1  current beat is the final beat of the frame
- `O_drop`  out  1  one-cycle pulse: the accepted frame produced zero beats

## Operation
FSM has two states, IDLE and SEND. Reset state is IDLE.

**Load.** On a rising edge in IDLE with `I0=1`:
- Register `I1`, `I3_B`, `I3_C` and `rev = I2_C`.
- Register `mask = I2_B ? I3_B : all-ones`.

**Empty frame.**
- If the computed mask is 0, stay in IDLE and pulse `O_drop` for the following cycle.
- `I_ready` remains 1 throughout.

**Non-empty frame.**
- Go to SEND.
- Current index = first set mask bit, scanning 0 upward when `rev=0` and N-1 downward when `rev=1`.

**SEND.**
- `O_valid=1`.
- `O_B` and `O_C` are the registered fields at `O_idx`; `O_tag` is the registered tag.
- `O_last=1` when no further set mask bit exists beyond `O_idx` in the scan direction.

**Beat handshake.** On `O_valid & O_ready`:
- If `O_last`, go to IDLE.
- Otherwise advance `O_idx` to the next set mask bit in scan direction. Unmasked entries cost no cycles.

**Input side.**
- `I_ready = (state == IDLE)`.
- `I0` in SEND is ignored and the data is not captured.
- Input ports are sampled only at the load edge.

**Reset.** `ASYNCRESET` asserted at any time, including mid-frame, aborts the frame immediately: state goes to IDLE and every register clears. The partial frame is discarded and no `O_last` is emitted.

## Timing
Reset values:
- `I_ready=1`
- `O_valid=0`, `O_last=0`, `O_drop=0`
- `O_tag=0`, `O_idx=0`, `O_B=0`, `O_C=0`

Latency and throughput:
- Frame accepted at edge t, then `O_valid=1` from cycle t+1.
- With `O_ready` held high, K beats occupy cycles t+1..t+K.
- IDLE is re-entered at edge t+K, so the next load is possible at edge t+K+1.
- A frame of K set bits therefore costs K+1 cycles.

Handshake and output rules:
- While `O_valid & !O_ready`, all `O_*` outputs are held stable.
- `O_valid` never drops without a handshake, except on reset.
- `O_last` is asserted only together with `O_valid`.
- All outputs are registered or decoded from registers only. There is no combinational path from `I*` or `O_ready` to any output.
- `O_drop` is never asserted together with `O_valid`.

Boundary cases:
- A single-bit mask produces one beat with `O_last=1` on its first cycle.
- Full mask (or `I2_B=0`) produces exactly N beats.

## Test plan
- **Forward, no compaction.** Reset, then load I1=5'h13, I2_B=0, I2_C=0, I3_B=5'b10110, I3_C=5'b01101 with `O_ready=1`. Required: 5 beats with idx 0..4, (B,C) = (0,1),(1,0),(1,1),(0,1),(1,0), tag 0x13 on every beat, `O_last` only on idx 4.
- **Compaction + reverse.** Same data with I2_B=1, I2_C=1. Required: beats at idx 4,2,1 only, `O_last` on idx 1, then `I_ready=1` on the next cycle.
- **Empty mask.** I2_B=1, I3_B=0. Required: no `O_valid`, `O_drop`=1 for exactly one cycle, `I_ready` stays 1.
- **Backpressure.** During the first test, hold `O_ready=0` for 3 cycles at idx 2. Required: idx 2 and its fields stay stable, then the frame resumes without loss or duplication. Assert `I0=1` in SEND: the frame is ignored.
- **Mid-frame reset.** Assert `ASYNCRESET` between clock edges during idx 1. Required: outputs reach their reset values immediately. After release, a new load emits from its own first index.
- **Back-to-back frames.** Strobe `I0` continuously. Required: frames of K beats are separated by exactly one idle cycle and each frame carries its own tag.
